end_msg_ctrl: RTL and testbench
===============================

# end_msg_ctrl

End-of-game message controller. It watches the game result levels and schedules the end-screen text overlay. It latches which message to show (won or over), blinks it for a fixed number of frames, then holds it steady until the player requests a restart. After that it runs a restart handshake with the game logic and re-arms only once both result levels have dropped. Its `disp_en` and `msg_sel` outputs gate and select the 16x16 text generator that feeds the shared font ROM and rectangle-char drawer.

## Interface
Parameters:
- `BLINK_FRAMES`, default 30: frames per blink half-period (on or off); must be ≥1.
- `BLINKS`, default 3: number of full off/on blink cycles before steady hold; must be ≥1.

Ports:
- `clk`  in  1  system/pixel clock; single clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `game_over`  in  1  level; the game is lost.
- `game_won`  in  1  level; the game is won.
- `frame_tick`  in  1  one-cycle pulse, once per video frame.
- `restart`  in  1  one-cycle pulse from the debounced restart button.
- `restart_ack`  in  1  level/pulse from the game logic; it has accepted the restart.
- `disp_en`  out  1  overlay enable for the text generator.
- `msg_sel`  out  1  0 = "Game over", 1 = "You won"; valid whenever state≠IDLE.
- `restart_req`  out  1  held high until `restart_ack`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- All outputs are registered. Reset values: `disp_en`=0, `msg_sel`=0, `restart_req`=0, `busy`=0, state=IDLE. All counters are 0.
- `frame_cnt` width is $clog2(BLINK_FRAMES) (minimum 1). `tog_cnt` width is $clog2(2*BLINKS+1). Neither counter wraps beyond its terminal value; each is cleared on every state entry.
- State IDLE:
  - If `game_over|game_won` is high, go to BLINK.
  - On that transition: `msg_sel`←`game_won` (won has priority if both are high), `disp_en`←1, counters←0.
- State BLINK:
  - On `frame_tick`, if `frame_cnt`==BLINK_FRAMES-1, clear `frame_cnt`, toggle `disp_en`, and increment `tog_cnt`. Otherwise increment `frame_cnt`.
  - The toggle that brings `tog_cnt` to 2*BLINKS leaves `disp_en`=1 and moves to HOLD.
- State HOLD: `disp_en`=1 steady; `frame_tick` is ignored.
- Restart from BLINK or HOLD:
  - A `restart` pulse moves to REQ.
  - On that transition: `disp_en`←0, `restart_req`←1.
  - `restart` has priority over a `frame_tick` in the same cycle.
- State REQ:
  - Hold `restart_req`=1 and `disp_en`=0.
  - On `restart_ack` high, drop `restart_req`←0 and go to RELEASE.
  - `restart` pulses are ignored.
- State RELEASE:
  - Wait until `game_over`=0 and `game_won`=0 are both sampled, then go to IDLE with `busy`←0. This prevents re-triggering on stale result levels.
  - Both levels low in the same cycle as entry is allowed; the exit then occurs on the next edge.
- `msg_sel` is latched only on the IDLE→BLINK transition. Changes to the result inputs after that have no effect until the controller is back in IDLE.
- `restart` in IDLE is ignored.
- Asserting `rst` in any state returns immediately (asynchronously) to the reset values. A pending handshake is abandoned, and `restart_req` drops without waiting for `restart_ack`.

## Timing
- IDLE→BLINK: `disp_en` and `busy` rise on the clock edge that samples the result level high (1-cycle latency).
- Blink toggle: `disp_en` changes on the edge that samples the BLINK_FRAMES-th `frame_tick` of a half-period.
- Total BLINK duration is 2*BLINKS*BLINK_FRAMES frame ticks.
- `restart` to `restart_req`/`disp_en`=0: 1 edge. `restart_ack` to `restart_req`=0: 1 edge.
- Shortest return to IDLE after the ack is 2 edges: REQ→RELEASE, then RELEASE→IDLE.

## Test plan
Use BLINK_FRAMES=2 and BLINKS=2 unless noted.
- **Reset, then game_over pulse:**
  - Check reset values first.
  - Raise `game_over`, then apply 8 `frame_tick`s.
  - Required: `disp_en` sequence 1,0,1,0,1 with a change every 2nd tick, `msg_sel`=0, state HOLD after tick 8, further ticks have no effect.
- **Both result levels high at once:** raise `game_over` and `game_won` in the same cycle. Required: `msg_sel`=1, and it stays 1 when `game_won` later drops.
- **Restart mid-BLINK, coinciding with a toggle tick:** issue `restart` together with the toggling `frame_tick`. Required: next cycle `disp_en`=0 and `restart_req`=1; no toggle is applied.
- **Handshake and release:**
  - Delay `restart_ack` by 5 cycles. Required: `restart_req` stays high for those 5 cycles and drops 1 edge after the ack.
  - Keep `game_over` high for 10 more cycles. Required: `busy` stays 1 and the controller does not re-enter BLINK; `busy`=0 one edge after `game_over` falls.
- **Restart in IDLE and during REQ:** issue a `restart` pulse in each state. Required: no state change and `restart_req` unaffected.
- **Async reset mid-REQ:** assert `rst` between clock edges while in REQ. Required: `restart_req`, `disp_en` and `busy` go to 0 before the next edge; after release, a new `game_won` restarts at BLINK with `msg_sel`=1.

Source files
------------

// File: rtl/end_msg_ctrl.sv
// End-of-game message controller: latches won/over, blinks the overlay,
// holds it steady, then runs a restart handshake before re-arming.
module end_msg_ctrl #(
  parameter int BLINK_FRAMES = 30,
  parameter int BLINKS       = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic game_over,
  input  logic game_won,
  input  logic frame_tick,
  input  logic restart,
  input  logic restart_ack,
  output logic disp_en,
  output logic msg_sel,
  output logic restart_req,
  output logic busy
);

  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int TW = $clog2(2 * BLINKS + 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [TW-1:0] TOG_LAST   = TW'(2 * BLINKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    BLINK,
    HOLD,
    REQ,
    RELEASE
  } state_t;

  state_t          state, state_nxt;
  logic [FW-1:0]   frame_cnt, frame_cnt_nxt;
  logic [TW-1:0]   tog_cnt, tog_cnt_nxt;
  logic            disp_en_nxt, msg_sel_nxt, restart_req_nxt, busy_nxt;
  logic            half_done;

  // A half-period ends on the tick that finds frame_cnt at its last value.
  assign half_done = (state == BLINK) && frame_tick && (frame_cnt == FRAME_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      frame_cnt   <= '0;
      tog_cnt     <= '0;
      disp_en     <= 1'b0;
      msg_sel     <= 1'b0;
      restart_req <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      frame_cnt   <= frame_cnt_nxt;
      tog_cnt     <= tog_cnt_nxt;
      disp_en     <= disp_en_nxt;
      msg_sel     <= msg_sel_nxt;
      restart_req <= restart_req_nxt;
      busy        <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (game_over || game_won) state_nxt = BLINK;
      BLINK: begin
        if (restart) state_nxt = REQ;
        else if (half_done && (tog_cnt == TOG_LAST)) state_nxt = HOLD;
      end
      HOLD:    if (restart) state_nxt = REQ;
      REQ:     if (restart_ack) state_nxt = RELEASE;
      RELEASE: if (!game_over && !game_won) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs are derived from the (state, state_nxt) transition,
  // so a restart in BLINK masks a coincident toggle automatically.
  always_comb begin
    frame_cnt_nxt   = frame_cnt;
    tog_cnt_nxt     = tog_cnt;
    disp_en_nxt     = disp_en;
    msg_sel_nxt     = msg_sel;
    restart_req_nxt = (state_nxt == REQ);
    busy_nxt        = (state_nxt != IDLE);

    if (state_nxt != state) begin
      frame_cnt_nxt = '0;
      tog_cnt_nxt   = '0;
    end else if (half_done) begin
      frame_cnt_nxt = '0;
      tog_cnt_nxt   = tog_cnt + 1'b1;
    end else if ((state == BLINK) && frame_tick) begin
      frame_cnt_nxt = frame_cnt + 1'b1;
    end

    if ((state == IDLE) && (state_nxt == BLINK)) msg_sel_nxt = game_won;

    case (state_nxt)
      BLINK: begin
        if (state == IDLE) disp_en_nxt = 1'b1;
        else if (half_done) disp_en_nxt = ~disp_en;
      end
      HOLD:    disp_en_nxt = 1'b1;
      default: disp_en_nxt = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_end_msg_ctrl.sv
// Directed self-checking bench for end_msg_ctrl with BLINK_FRAMES=2, BLINKS=2.
module tb_end_msg_ctrl;

  logic clk = 1'b0;
  logic rst, game_over, game_won, frame_tick, restart, restart_ack;
  logic disp_en, msg_sel, restart_req, busy;

  int errors = 0;
  int checks = 0;

  end_msg_ctrl #(
    .BLINK_FRAMES(2),
    .BLINKS      (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .game_over  (game_over),
    .game_won   (game_won),
    .frame_tick (frame_tick),
    .restart    (restart),
    .restart_ack(restart_ack),
    .disp_en    (disp_en),
    .msg_sel    (msg_sel),
    .restart_req(restart_req),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expected disp_en after each of the 8 blink ticks.
  logic exp_blink [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    rst = 1'b1; game_over = 1'b0; game_won = 1'b0;
    frame_tick = 1'b0; restart = 1'b0; restart_ack = 1'b0;
    cyc(); cyc();
    check("rst_disp_en", disp_en, 1'b0);
    check("rst_msg_sel", msg_sel, 1'b0);
    check("rst_restart_req", restart_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    cyc();

    // game_over -> BLINK, then 8 ticks of blinking into HOLD
    game_over = 1'b1;
    cyc();
    check("enter_disp_en", disp_en, 1'b1);
    check("enter_busy", busy, 1'b1);
    check("enter_msg_sel", msg_sel, 1'b0);
    for (int i = 0; i < 8; i++) begin
      frame_tick = 1'b1; cyc();
      frame_tick = 1'b0;
      check($sformatf("blink_tick%0d", i + 1), disp_en, exp_blink[i]);
      cyc();
    end
    for (int i = 0; i < 4; i++) begin
      frame_tick = 1'b1; cyc();
      frame_tick = 1'b0;
      check($sformatf("hold_tick%0d", i), disp_en, 1'b1);
    end
    check("hold_msg_sel", msg_sel, 1'b0);

    // restart from HOLD, delayed ack, restart ignored in REQ
    restart = 1'b1; cyc(); restart = 1'b0;
    check("req_disp_en", disp_en, 1'b0);
    check("req_restart_req", restart_req, 1'b1);
    for (int i = 0; i < 5; i++) begin
      restart = (i == 2);
      cyc();
      check($sformatf("req_wait%0d", i), restart_req, 1'b1);
      check($sformatf("req_wait_disp%0d", i), disp_en, 1'b0);
    end
    restart = 1'b0;
    restart_ack = 1'b1; cyc(); restart_ack = 1'b0;
    check("ack_restart_req", restart_req, 1'b0);
    check("ack_busy", busy, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cyc();
      check($sformatf("release_busy%0d", i), busy, 1'b1);
      check($sformatf("release_disp%0d", i), disp_en, 1'b0);
    end
    game_over = 1'b0; cyc();
    check("idle_busy", busy, 1'b0);

    // both results high: won wins and stays latched
    game_over = 1'b1; game_won = 1'b1; cyc();
    check("both_msg_sel", msg_sel, 1'b1);
    check("both_disp_en", disp_en, 1'b1);
    game_won = 1'b0; cyc();
    check("won_drop_msg_sel", msg_sel, 1'b1);

    // restart on a toggle tick where the toggle would raise disp_en
    frame_tick = 1'b1; cyc();
    cyc(); frame_tick = 1'b0;
    check("mid_toggle_off", disp_en, 1'b0);
    frame_tick = 1'b1; cyc();
    restart = 1'b1; cyc();
    restart = 1'b0; frame_tick = 1'b0;
    check("prio_disp_en", disp_en, 1'b0);
    check("prio_restart_req", restart_req, 1'b1);
    check("prio_msg_sel", msg_sel, 1'b1);

    // ack with results already low: two edges back to IDLE
    restart_ack = 1'b1; game_over = 1'b0; cyc(); restart_ack = 1'b0;
    check("fast_rel_req", restart_req, 1'b0);
    check("fast_rel_busy", busy, 1'b1);
    cyc();
    check("fast_idle_busy", busy, 1'b0);

    // restart in IDLE is ignored
    restart = 1'b1; cyc(); restart = 1'b0;
    check("idle_restart_busy", busy, 1'b0);
    check("idle_restart_req", restart_req, 1'b0);
    check("idle_restart_disp", disp_en, 1'b0);

    // async reset while in REQ
    game_over = 1'b1; cyc();
    restart = 1'b1; cyc(); restart = 1'b0;
    check("pre_rst_req", restart_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_req", restart_req, 1'b0);
    check("async_rst_disp", disp_en, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    game_over = 1'b0; game_won = 1'b1;
    #1 rst = 1'b0;
    cyc();
    check("post_rst_disp", disp_en, 1'b1);
    check("post_rst_msg_sel", msg_sel, 1'b1);
    check("post_rst_busy", busy, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
